// File: rtl/la_pll_lock_ctrl.sv
// PLL supervisor: sequences PLL/output-divider resets, waits for stable lock with timeout/retry.
// Optional loss counter output enabled by LA_PLL_LOCK_CTRL_LOSS_CNT_EN.
module la_pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned RELEASE_CYCLES = 8,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_rst,
  output logic       rstodiv,
  output logic       user_rst,
  output logic       ready,
  output logic       fail,
`ifdef LA_PLL_LOCK_CTRL_LOSS_CNT_EN
  output logic [7:0] loss_cnt,
`endif
  output logic [3:0] retry_cnt
);

  // state     | meaning
  // S_RESET   | PLL and divider held in reset for RST_CYCLES
  // S_WAIT    | PLL released, waiting for lock up to LOCK_TIMEOUT
  // S_STABLE  | lock seen, must stay high for STABLE_CYCLES
  // S_RELEASE | divider released, user reset held RELEASE_CYCLES
  // S_RUN     | sampling domain out of reset
  // S_FAIL    | retries exhausted, waits for restart or rst
  typedef enum logic [2:0] {
    S_RESET, S_WAIT, S_STABLE, S_RELEASE, S_RUN, S_FAIL
  } state_t;

  localparam logic [19:0] RST_LAST     = 20'(RST_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] STABLE_LAST  = 20'(STABLE_CYCLES - 1);
  localparam logic [19:0] RELEASE_LAST = 20'(RELEASE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

  state_t      state, state_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic [3:0]  retry_nxt;
  logic        lock_m, lock_s;
  logic        pll_rst_nxt, rstodiv_nxt, user_rst_nxt, ready_nxt, fail_nxt;
`ifdef LA_PLL_LOCK_CTRL_LOSS_CNT_EN
  logic        loss_evt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 20'd1;
    retry_nxt = retry_cnt;
`ifdef LA_PLL_LOCK_CTRL_LOSS_CNT_EN
    loss_evt  = 1'b0;
`endif
    if (restart) begin
      state_nxt = S_RESET;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end else begin
      case (state)
        S_RESET: begin
          if (cnt == RST_LAST) begin
            state_nxt = S_WAIT;
            cnt_nxt   = '0;
          end
        end
        S_WAIT: begin
          // lock wins over a coincident timeout
          if (lock_s) begin
            state_nxt = S_STABLE;
            cnt_nxt   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_nxt = '0;
            if (retry_cnt == RETRY_MAX) begin
              state_nxt = S_FAIL;
            end else begin
              state_nxt = S_RESET;
              retry_nxt = retry_cnt + 4'd1;
            end
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_nxt = S_WAIT;
            cnt_nxt   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = S_RELEASE;
            cnt_nxt   = '0;
          end
        end
        S_RELEASE: begin
          if (!lock_s) begin
            state_nxt = S_RESET;
            cnt_nxt   = '0;
`ifdef LA_PLL_LOCK_CTRL_LOSS_CNT_EN
            loss_evt  = 1'b1;
`endif
          end else if (cnt == RELEASE_LAST) begin
            state_nxt = S_RUN;
            cnt_nxt   = '0;
            retry_nxt = '0;
          end
        end
        S_RUN: begin
          cnt_nxt = cnt;
          if (!lock_s) begin
            state_nxt = S_RESET;
            cnt_nxt   = '0;
`ifdef LA_PLL_LOCK_CTRL_LOSS_CNT_EN
            loss_evt  = 1'b1;
`endif
          end
        end
        S_FAIL: cnt_nxt = cnt;
        default: begin
          state_nxt = S_RESET;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // outputs decoded from the next state so they register on the same edge
  always_comb begin
    pll_rst_nxt  = 1'b1;
    rstodiv_nxt  = 1'b1;
    user_rst_nxt = 1'b1;
    ready_nxt    = 1'b0;
    fail_nxt     = 1'b0;
    case (state_nxt)
      S_WAIT, S_STABLE: pll_rst_nxt = 1'b0;
      S_RELEASE: begin
        pll_rst_nxt = 1'b0;
        rstodiv_nxt = 1'b0;
      end
      S_RUN: begin
        pll_rst_nxt  = 1'b0;
        rstodiv_nxt  = 1'b0;
        user_rst_nxt = 1'b0;
        ready_nxt    = 1'b1;
      end
      S_FAIL: fail_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RESET;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      rstodiv   <= 1'b1;
      user_rst  <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      pll_rst   <= pll_rst_nxt;
      rstodiv   <= rstodiv_nxt;
      user_rst  <= user_rst_nxt;
      ready     <= ready_nxt;
      fail      <= fail_nxt;
    end
  end

`ifdef LA_PLL_LOCK_CTRL_LOSS_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt <= '0;
    end else if (loss_evt && !restart && loss_cnt != 8'hFF) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`endif

endmodule
